// File: rtl/dot_product_engine.sv
// -----------------------------------------------------------------------------
// dot_product_engine
//
// Computes NUM_VECTORS dot products per run. Each vector pair is VECTOR_WIDTH
// unsigned elements read from two source memories (A and B) that share one
// read strobe and one address. Memory data arrives one cycle after the read
// strobe; each element product is accumulated at full width.
//
// Per vector pair: FETCH (VECTOR_WIDTH cycles) -> DRAIN -> EMIT -> DONE.
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   start               begins a run when sampled high in IDLE
//   read_en             read strobe for both source memories
//   read_address        shared read address (wraps modulo 2^ADDR_WIDTH)
//   a_data, b_data      element data, valid one cycle after read_en
//   dot_product_result  registered result, held between EMIT cycles
//   result_valid        one-cycle pulse per completed vector pair (EMIT)
//   processing_done     one-cycle pulse the cycle after result_valid (DONE)
//   busy                high in every state except IDLE
// -----------------------------------------------------------------------------
module dot_product_engine #(
    parameter int DATA_WIDTH   = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int ADDR_WIDTH   = 4,
    parameter int NUM_VECTORS  = 4,
    parameter int RESULT_WIDTH = 2 * DATA_WIDTH + $clog2(VECTOR_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    read_en,
    output logic [ADDR_WIDTH-1:0]   read_address,
    input  logic [DATA_WIDTH-1:0]   a_data,
    input  logic [DATA_WIDTH-1:0]   b_data,
    output logic [RESULT_WIDTH-1:0] dot_product_result,
    output logic                    result_valid,
    output logic                    processing_done,
    output logic                    busy
);

    localparam int EIDX_W = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
    // vec_idx must be able to hold NUM_VECTORS itself after the last DONE.
    localparam int VIDX_W = $clog2(NUM_VECTORS + 1);

    localparam logic [EIDX_W-1:0] ELEM_LAST = EIDX_W'(VECTOR_WIDTH - 1);
    localparam logic [VIDX_W-1:0] VEC_COUNT = VIDX_W'(NUM_VECTORS);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        EMIT,
        DONE
    } state_t;

    state_t                  state;
    state_t                  next_state;

    logic [EIDX_W-1:0]       elem_idx;
    logic [VIDX_W-1:0]       vec_idx;
    logic [VIDX_W-1:0]       vec_idx_inc;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [RESULT_WIDTH-1:0] acc;
    logic [RESULT_WIDTH-1:0] acc_sum;
    logic [RESULT_WIDTH-1:0] result_q;
    logic [2*DATA_WIDTH-1:0] product;
    logic                    data_pending;
    logic                    clear_run;
    logic                    clear_acc;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic and run-control strobes
    // -------------------------------------------------------------------------
    assign vec_idx_inc = vec_idx + 1'b1;

    always_comb begin
        next_state = state;
        clear_run  = 1'b0;
        clear_acc  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = FETCH;
                    clear_run  = 1'b1;
                    clear_acc  = 1'b1;
                end
            end
            FETCH: begin
                if (elem_idx == ELEM_LAST) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                next_state = EMIT;
            end
            EMIT: begin
                next_state = DONE;
            end
            DONE: begin
                if (vec_idx_inc < VEC_COUNT) begin
                    next_state = FETCH;
                    clear_acc  = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    assign product = {{DATA_WIDTH{1'b0}}, a_data} * {{DATA_WIDTH{1'b0}}, b_data};
    assign acc_sum = acc + RESULT_WIDTH'(product);

    // The address is vec_idx*VECTOR_WIDTH + elem_idx, which advances by one
    // on every FETCH cycle across the whole run, so a free-running counter
    // that wraps at ADDR_WIDTH bits produces the same sequence without a
    // multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            elem_idx     <= '0;
            vec_idx      <= '0;
            addr_q       <= '0;
            acc          <= '0;
            result_q     <= '0;
            data_pending <= 1'b0;
        end else begin
            data_pending <= (state == FETCH);

            if (clear_run) begin
                vec_idx <= '0;
                addr_q  <= '0;
            end else if (state == FETCH) begin
                addr_q  <= addr_q + 1'b1;
            end else if (state == DONE) begin
                vec_idx <= vec_idx_inc;
            end

            if (clear_acc) begin
                elem_idx <= '0;
            end else if (state == FETCH) begin
                elem_idx <= (elem_idx == ELEM_LAST) ? '0 : elem_idx + 1'b1;
            end

            // Data returned for the previous cycle's read is summed here; the
            // clear only happens in IDLE/DONE where no read is outstanding.
            if (clear_acc) begin
                acc <= '0;
            end else if (data_pending) begin
                acc <= acc_sum;
            end

            // DRAIN absorbs the last product, so capture the completed sum
            // directly so it is already registered during EMIT.
            if (state == DRAIN) begin
                result_q <= acc_sum;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign read_en            = (state == FETCH);
    assign read_address       = (state == FETCH) ? addr_q : '0;
    assign dot_product_result = result_q;
    assign result_valid       = (state == EMIT);
    assign processing_done    = (state == DONE);
    assign busy               = (state != IDLE);

endmodule

// File: doc/dot_product_engine.md
DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the element width in bits (unsigned).
REQ-002 SHALL have parameter VECTOR_WIDTH, default 4, giving the number of elements per vector (power of two).
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, giving the source memory address width.
REQ-004 SHALL have parameter NUM_VECTORS, default 4, giving the vector pairs per run (1..7).
REQ-005 SHALL have parameter RESULT_WIDTH, default 2*DATA_WIDTH+$clog2(VECTOR_WIDTH), giving the result width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1 bit: begins a run when sampled high in IDLE.
REQ-009 SHALL have port read_en, output, 1 bit: read strobe shared by both source memories.
REQ-010 SHALL have port read_address, output, ADDR_WIDTH bits: address shared by both source memories.
REQ-011 SHALL have port a_data, input, DATA_WIDTH bits: vector A element, valid one cycle after read_en.
REQ-012 SHALL have port b_data, input, DATA_WIDTH bits: vector B element, valid one cycle after read_en.
REQ-013 SHALL have port dot_product_result, output, RESULT_WIDTH bits: registered result.
REQ-014 SHALL have port result_valid, output, 1 bit: one-cycle pulse per completed vector pair.
REQ-015 SHALL have port processing_done, output, 1 bit: one-cycle pulse the cycle after each result_valid.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, FETCH, DRAIN, EMIT and DONE.
REQ-018 IDLE→FETCH SHALL occur on start=1; the vector index, element index and accumulator SHALL clear on entering FETCH from IDLE.
REQ-019 FETCH SHALL last VECTOR_WIDTH cycles; each cycle read_en=1 and read_address=(vec_idx*VECTOR_WIDTH+elem_idx) mod 2^ADDR_WIDTH, with elem_idx running 0..VECTOR_WIDTH-1.
REQ-020 A read issued in cycle k SHALL see its data in cycle k+1; the accumulator SHALL add a_data*b_data (unsigned, full width) at the end of cycle k+1.
REQ-021 DRAIN SHALL last 1 cycle with read_en=0 and SHALL absorb the last element product.
REQ-022 EMIT SHALL last 1 cycle with result_valid=1 and dot_product_result equal to the final accumulator value.
REQ-023 DONE SHALL last 1 cycle with processing_done=1 and SHALL increment vec_idx.
REQ-024 DONE SHALL go to FETCH (accumulator cleared) if vec_idx < NUM_VECTORS, else to IDLE.
REQ-025 Latency: with start sampled at edge N, read_en SHALL be high in cycles N+1..N+V, result_valid in N+V+2, processing_done in N+V+3, and the next vector's FETCH SHALL begin in N+V+4.
REQ-026 The accumulator SHALL NOT overflow by construction, and no saturation logic is required.
REQ-027 dot_product_result SHALL hold its value between EMIT cycles.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 read_address SHALL wrap modulo 2^ADDR_WIDTH.
REQ-030 read_en, result_valid and processing_done SHALL never be high in the same cycle.

Reset
REQ-031 On rst_n=0, asynchronously: state=IDLE and every output plus all indices and the accumulator SHALL be 0.
REQ-032 Reset mid-run SHALL abort the run; the next start SHALL restart at address 0 with a cleared accumulator.

Verification
REQ-033 Scenario: A=[1,2,3,4] and B=[5,6,7,8] at addresses 0-3, start pulse → reads 0..3, result_valid with dot_product_result=70, processing_done the next cycle.
REQ-034 Scenario: all elements 255 → result 260100 (0x3F804), with no truncation at 18 bits.
REQ-035 Scenario: NUM_VECTORS=4 → addresses 0..15 read in order, exactly 4 result_valid and 4 processing_done pulses, busy low after the last DONE.
REQ-036 Scenario: start re-asserted during FETCH → no restart, no extra reads, identical results.
REQ-037 Scenario: rst_n low in the 2nd FETCH cycle → all outputs 0 immediately; a fresh start yields the correct 70 from address 0.
REQ-038 Scenario: all-zero vectors → result_valid still pulses with dot_product_result=0.
